// File: rtl/vga_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_ctrl
// Description : VGA timing generator for 640x480@60 Hz on a 25 MHz pixel clock.
//               Keeps the horizontal and vertical counters. Decodes hsync,
//               vsync and frame_start from them. Requests pixel coordinates
//               one clock before display, so that a pixel stage with a
//               registered output returns its colour exactly in the visible
//               window. Gates that colour onto rgb.
//
// Ports       : vga_clk      in   pixel clock (25 MHz)
//               sys_rst_n    in   asynchronous, active-low reset
//               pix_data     in   [15:0] RGB565 from pixel stage (1-cycle latency)
//               pix_x        out  [9:0]  requested column, 10'h3FF when idle
//               pix_y        out  [9:0]  requested row,    10'h3FF when idle
//               hsync        out  horizontal sync, high during sync pulse
//               vsync        out  vertical sync, high during sync pulse
//               rgb          out  [15:0] RGB565 to DAC, zero outside window
//               frame_start  out  high while cnt_h==0 and cnt_v==0
//
// Revision    : 1.0  initial release
// ============================================================================
module vga_ctrl #(
    parameter logic [9:0] H_SYNC   = 10'd96,
    parameter logic [9:0] H_BACK   = 10'd40,
    parameter logic [9:0] H_LEFT   = 10'd8,
    parameter logic [9:0] H_VALID  = 10'd640,
    parameter logic [9:0] H_RIGHT  = 10'd8,
    parameter logic [9:0] H_FRONT  = 10'd8,
    parameter logic [9:0] H_TOTAL  = 10'd800,
    parameter logic [9:0] V_SYNC   = 10'd2,
    parameter logic [9:0] V_BACK   = 10'd25,
    parameter logic [9:0] V_TOP    = 10'd8,
    parameter logic [9:0] V_VALID  = 10'd480,
    parameter logic [9:0] V_BOTTOM = 10'd8,
    parameter logic [9:0] V_FRONT  = 10'd2,
    parameter logic [9:0] V_TOTAL  = 10'd525
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        frame_start
);

    // ------------------------------------------------------------------
    // Derived window positions
    // ------------------------------------------------------------------
    localparam logic [9:0] c_h_start = H_SYNC + H_BACK + H_LEFT;        // first visible column
    localparam logic [9:0] c_h_end   = c_h_start + H_VALID - 10'd1;     // last visible column
    localparam logic [9:0] c_v_start = V_SYNC + V_BACK + V_TOP;         // first visible line
    localparam logic [9:0] c_v_end   = c_v_start + V_VALID - 10'd1;     // last visible line
    localparam logic [9:0] c_h_last  = H_TOTAL - 10'd1;
    localparam logic [9:0] c_v_last  = V_TOTAL - 10'd1;

    // Requests lead the visible window by one clock to cover the pixel
    // stage's register.
    localparam logic [9:0] c_req_start = c_h_start - 10'd1;
    localparam logic [9:0] c_req_end   = c_h_end - 10'd1;

    // The totals must equal the sum of their segments, otherwise the
    // window decode and the wrap points disagree.
    localparam logic [9:0] c_h_sum = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
    localparam logic [9:0] c_v_sum = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;

    generate
        if (c_h_sum != H_TOTAL) begin : g_bad_h_total
            $error("vga_ctrl: H_TOTAL does not match the sum of the horizontal segments");
        end
        if (c_v_sum != V_TOTAL) begin : g_bad_v_total
            $error("vga_ctrl: V_TOTAL does not match the sum of the vertical segments");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    logic [9:0] r_cnt_h;
    logic [9:0] r_cnt_v;
    logic       w_h_wrap;
    logic       w_v_wrap;

    assign w_h_wrap = (r_cnt_h == c_h_last);
    assign w_v_wrap = (r_cnt_v == c_v_last);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_h <= 10'd0;
        end else if (w_h_wrap) begin
            r_cnt_h <= 10'd0;
        end else begin
            r_cnt_h <= r_cnt_h + 10'd1;
        end
    end

    // The line counter only moves on the last column of a line, and the
    // frame wraps on that same clock.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_v <= 10'd0;
        end else if (w_h_wrap) begin
            if (w_v_wrap) begin
                r_cnt_v <= 10'd0;
            end else begin
                r_cnt_v <= r_cnt_v + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational decodes (no latency relative to the counters)
    // ------------------------------------------------------------------
    logic w_v_active;
    logic w_rgb_valid;
    logic w_pix_req;

    assign w_v_active  = (r_cnt_v >= c_v_start) && (r_cnt_v <= c_v_end);
    assign w_rgb_valid = (r_cnt_h >= c_h_start) && (r_cnt_h <= c_h_end) && w_v_active;
    assign w_pix_req   = (r_cnt_h >= c_req_start) && (r_cnt_h <= c_req_end) && w_v_active;

    assign hsync       = (r_cnt_h <= H_SYNC - 10'd1);
    assign vsync       = (r_cnt_v <= V_SYNC - 10'd1);
    assign frame_start = (r_cnt_h == 10'd0) && (r_cnt_v == 10'd0);

    assign pix_x = w_pix_req ? (r_cnt_h - c_req_start) : 10'h3FF;
    assign pix_y = w_pix_req ? (r_cnt_v - c_v_start)   : 10'h3FF;

    // Outside the window pix_data may be undefined, so it is never passed.
    assign rgb = w_rgb_valid ? pix_data : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_vga_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_ctrl
// Description : Scoreboard bench for vga_ctrl. Full horizontal timing, with a
//               shortened vertical frame (17 lines, visible lines 7..12) so
//               that several whole frames fit in a short run. A per-cycle
//               expectation is queued on every clock edge and popped by a
//               monitor on the falling edge. Hand-computed coordinate
//               vectors and per-frame totals are checked alongside it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_ctrl;

    localparam int H_TOT = 800;
    localparam int H_SY  = 96;
    localparam int H_ST  = 144;
    localparam int H_VAL = 640;
    localparam int V_SY  = 2;
    localparam int V_TOT = 17;   // 2+3+2+6+2+2
    localparam int V_ST  = 7;    // 2+3+2
    localparam int V_VAL = 6;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int N_TAB = 15;
    localparam int MAX_FAIL = 40;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic [15:0] rgb;
    logic        frame_start;

    logic        mode;       // 0: pixel-stage pattern, 1: constant FFFF
    logic [15:0] pix_reg;

    int n_pass  = 0;
    int n_total = 0;

    vga_ctrl #(
        .V_SYNC   (10'd2),
        .V_BACK   (10'd3),
        .V_TOP    (10'd2),
        .V_VALID  (10'd6),
        .V_BOTTOM (10'd2),
        .V_FRONT  (10'd2),
        .V_TOTAL  (10'd17)
    ) dut (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    always #20 vga_clk = ~vga_clk;

    // Pixel stage: one register of {y[5:0], x}; undefined when not requested.
    always @(posedge vga_clk)
        pix_reg <= (pix_x == 10'h3FF) ? 16'hxxxx : {pix_y[5:0], pix_x};

    assign pix_data = mode ? 16'hFFFF : pix_reg;

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    task automatic finish_run;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    endtask

    task automatic chk(input bit ok, input string msg);
        n_total++;
        if (ok) n_pass++;
        else begin
            $display("FAIL %s", msg);
            if (n_total - n_pass > MAX_FAIL) finish_run();
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard queue
    // ------------------------------------------------------------------
    typedef struct {
        int          h;
        int          v;
        logic        m;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   m_h = 0;
    int   m_v = 0;

    function automatic exp_t model(input int h, input int v, input logic m);
        exp_t       e;
        logic [9:0] xx;
        logic [9:0] yy;
        bit         vact;
        bit         req;
        bit         val;
        vact  = (v >= V_ST) && (v <= V_ST + V_VAL - 1);
        req   = (h >= H_ST - 1) && (h <= H_ST + H_VAL - 2) && vact;
        val   = (h >= H_ST) && (h <= H_ST + H_VAL - 1) && vact;
        e.h   = h;
        e.v   = v;
        e.m   = m;
        e.px  = req ? 10'(h - (H_ST - 1)) : 10'h3FF;
        e.py  = req ? 10'(v - V_ST) : 10'h3FF;
        e.hs  = (h < H_SY);
        e.vs  = (v < V_SY);
        e.fs  = (h == 0) && (v == 0);
        xx    = 10'(h - H_ST);
        yy    = 10'(v - V_ST);
        e.rgb = !val ? 16'h0000 : (m ? 16'hFFFF : {yy[5:0], xx});
        return e;
    endfunction

    // Expected values for the cycle that starts at this edge.
    always @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            m_h = 0;
            m_v = 0;
        end else if (m_h == H_TOT - 1) begin
            m_h = 0;
            m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
        exp_q.push_back(model(m_h, m_v, mode));
    end

    // Hand-computed vectors (h, v) -> outputs; rgb column applies to pattern mode.
    int          t_h  [N_TAB] = '{0, 95, 96, 799, 0, 142, 143, 144, 782, 783, 784, 143, 783, 782, 799};
    int          t_v  [N_TAB] = '{0, 0, 0, 1, 2, 7, 7, 7, 7, 7, 7, 12, 12, 13, 16};
    logic [9:0]  t_px [N_TAB] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'd0, 10'd1,
                                  10'd639, 10'h3FF, 10'h3FF, 10'd0, 10'h3FF, 10'h3FF, 10'h3FF};
    logic [9:0]  t_py [N_TAB] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'd0, 10'd0,
                                  10'd0, 10'h3FF, 10'h3FF, 10'd5, 10'h3FF, 10'h3FF, 10'h3FF};
    logic        t_hs [N_TAB] = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic        t_vs [N_TAB] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic        t_fs [N_TAB] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] t_rgb[N_TAB] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                                  16'h027E, 16'h027F, 16'h0, 16'h0, 16'h167F, 16'h0, 16'h0};

    // ------------------------------------------------------------------
    // Monitor: pops one expectation per cycle, plus per-frame totals
    // ------------------------------------------------------------------
    int   cyc   = 0;
    int   hs_c  = 0;
    int   vs_c  = 0;
    int   ff_c  = 0;
    logic fmode = 1'b0;
    bit   seen_fs = 1'b0;

    always @(negedge vga_clk) begin
        exp_t e;
        bit   ok;
        if (exp_q.size() == 0) begin
            chk(1'b0, "scoreboard_empty: got no queued expectation, required one per cycle");
        end else begin
            e = exp_q.pop_front();
            chk({pix_x, pix_y, hsync, vsync, frame_start, rgb} === {e.px, e.py, e.hs, e.vs, e.fs, e.rgb},
                $sformatf("cycle h=%0d v=%0d: got x=%h y=%h hs=%b vs=%b fs=%b rgb=%h, required x=%h y=%h hs=%b vs=%b fs=%b rgb=%h",
                          e.h, e.v, pix_x, pix_y, hsync, vsync, frame_start, rgb,
                          e.px, e.py, e.hs, e.vs, e.fs, e.rgb));
            for (int i = 0; i < N_TAB; i++) begin
                if (e.h == t_h[i] && e.v == t_v[i]) begin
                    ok = (pix_x === t_px[i]) && (pix_y === t_py[i]) && (hsync === t_hs[i]) &&
                         (vsync === t_vs[i]) && (frame_start === t_fs[i]) && (e.m || rgb === t_rgb[i]);
                    chk(ok, $sformatf("vector%0d h=%0d v=%0d: got x=%h y=%h hs=%b vs=%b fs=%b rgb=%h, required x=%h y=%h hs=%b vs=%b fs=%b rgb=%h",
                                      i, t_h[i], t_v[i], pix_x, pix_y, hsync, vsync, frame_start, rgb,
                                      t_px[i], t_py[i], t_hs[i], t_vs[i], t_fs[i], t_rgb[i]));
                end
            end
        end

        if (frame_start === 1'b1) begin
            if (seen_fs && sys_rst_n === 1'b1) begin
                chk(cyc == FRAME, $sformatf("frame_period: got %0d, required %0d", cyc, FRAME));
                chk(hs_c == H_SY * V_TOT, $sformatf("hsync_clocks: got %0d, required %0d", hs_c, H_SY * V_TOT));
                chk(vs_c == V_SY * H_TOT, $sformatf("vsync_clocks: got %0d, required %0d", vs_c, V_SY * H_TOT));
                chk(ff_c == (fmode ? H_VAL * V_VAL : 0),
                    $sformatf("rgb_ffff_count: got %0d, required %0d", ff_c, fmode ? H_VAL * V_VAL : 0));
            end
            seen_fs = 1'b1;
            cyc  = 0;
            hs_c = 0;
            vs_c = 0;
            ff_c = 0;
        end
        cyc++;
        if (hsync === 1'b1) hs_c++;
        if (vsync === 1'b1) vs_c++;
        if (rgb === 16'hFFFF) ff_c++;
        if (cyc == 2) fmode = mode;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic wait_fs(input int limit, input string tag);
        int n = 0;
        do begin
            @(negedge vga_clk);
            n++;
        end while (frame_start !== 1'b1 && n < limit);
        chk(frame_start === 1'b1,
            $sformatf("%s_timeout: got no frame_start in %0d clocks, required one", tag, limit));
    endtask

    initial begin
        mode      = 1'b0;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        #5 sys_rst_n = 1'b1;

        // Frame 1: pattern from the pixel stage.
        wait_fs(FRAME + 10, "frame1");
        #5 mode = 1'b1;

        // Frame 2: constant white input.
        wait_fs(FRAME + 10, "frame2");
        #5 mode = 1'b0;

        // Frame 3: reset mid-frame at h=400, v=9, between clock edges.
        repeat (9 * H_TOT + 400) @(negedge vga_clk);
        #5 sys_rst_n = 1'b0;
        exp_q.delete();
        #2;
        chk({pix_x, pix_y, hsync, vsync, frame_start, rgb} === {10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b1, 16'h0000},
            $sformatf("async_reset: got x=%h y=%h hs=%b vs=%b fs=%b rgb=%h, required x=3ff y=3ff hs=1 vs=1 fs=1 rgb=0000",
                      pix_x, pix_y, hsync, vsync, frame_start, rgb));
        repeat (3) @(negedge vga_clk);
        #5 sys_rst_n = 1'b1;

        // Full frame after release; its period is checked by the monitor.
        wait_fs(FRAME + 10, "post_reset");
        repeat (5) @(negedge vga_clk);
        finish_run();
    end

endmodule
`default_nettype wire

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
- VGA timing generator for the 640x480@60 Hz display path, driven by the 25 MHz pixel clock.
- Generates the horizontal/vertical counters, hsync/vsync, and the active-area window.
- Sits directly upstream of the pixel-colour stage. It issues pix_x/pix_y one cycle ahead of display so that stage's registered pix_data (1-cycle latency) lands exactly in the visible area.
- Gates returned pix_data onto rgb.

Parameters:
- H_SYNC, 10'd96, horizontal sync pulse width (clocks)
- H_BACK, 10'd40, horizontal back porch
- H_LEFT, 10'd8, left border
- H_VALID, 10'd640, active pixels per line
- H_RIGHT, 10'd8, right border
- H_FRONT, 10'd8, horizontal front porch
- H_TOTAL, 10'd800, line period = sum of all H_* above
- V_SYNC, 10'd2, vertical sync width (lines)
- V_BACK, 10'd25, vertical back porch
- V_TOP, 10'd8, top border
- V_VALID, 10'd480, active lines per frame
- V_BOTTOM, 10'd8, bottom border
- V_FRONT, 10'd2, vertical front porch
- V_TOTAL, 10'd525, frame period = sum of all V_* above

Ports:
- vga_clk  input  1  pixel clock, 25 MHz
- sys_rst_n  input  1  reset; asynchronous assert, active-low
- pix_data  input  16  RGB565 colour returned by the pixel stage, one cycle after pix_x/pix_y
- pix_x  output  10  X coordinate requested (0..639), 10'h3FF when no request
- pix_y  output  10  Y coordinate requested (0..479), 10'h3FF when no request
- hsync  output  1  horizontal sync, active-high during sync pulse
- vsync  output  1  vertical sync, active-high during sync pulse
- rgb  output  16  RGB565 to DAC; 0 outside the active window
- frame_start  output  1  one-cycle pulse when cnt_h==0 and cnt_v==0

Behaviour:
- Reset interface: one clock; reset is asynchronous and active-low (sys_rst_n), clocked on vga_clk.

Counters:
- cnt_h (10b) increments every clock; wraps H_TOTAL-1 -> 0.
- cnt_v (10b) increments only when cnt_h==H_TOTAL-1; wraps V_TOTAL-1 -> 0 on that same cycle.
- sys_rst_n low forces cnt_h=cnt_v=0 immediately, mid-line or mid-frame. The first clock edge after release moves cnt_h to 1.

All outputs below are combinational decodes of the counters (no extra latency).
- hsync = (cnt_h <= H_SYNC-1); vsync = (cnt_v <= V_SYNC-1).
- H_START = H_SYNC+H_BACK+H_LEFT = 144; V_START = V_SYNC+V_BACK+V_TOP = 35.
- rgb_valid (internal) = cnt_h in [144, 783] and cnt_v in [35, 514].
- pix_data_req (internal) = cnt_h in [143, 782] and cnt_v in [35, 514], i.e. one clock earlier than rgb_valid.
- pix_x = pix_data_req ? cnt_h-143 : 10'h3FF; pix_y = pix_data_req ? cnt_v-35 : 10'h3FF.
- rgb = rgb_valid ? pix_data : 16'h0000.
- frame_start = (cnt_h==0) && (cnt_v==0).

Reset values (during reset): cnt_h=cnt_v=0, so hsync=1, vsync=1, frame_start=1, pix_x=pix_y=10'h3FF, rgb=0.

Boundaries:
- Last request is at cnt_h=782 (pix_x=639); cnt_h=783 has no request but rgb_valid=1 and shows pixel 639.
- Line-wrap and frame-wrap cycles produce no request and rgb=0.
- pix_data is ignored whenever rgb_valid=0, including X values on the input.

Test Plan:
1. Reset, release, run 2 frames -> hsync high for exactly 96 clocks every 800; vsync high for exactly 2*800=1600 clocks every 525*800=420000; frame_start pulses every 420000 clocks.
2. At cnt_v=35: cnt_h=142 -> pix_x=3FF; cnt_h=143 -> pix_x=0, pix_y=0; cnt_h=782 -> pix_x=639; cnt_h=783 -> pix_x=3FF, rgb_valid still 1.
3. Model the pixel stage as a 1-cycle register of {pix_y[5:0], pix_x} -> rgb at cnt_h=144, cnt_v=35 equals 16'h0000; at cnt_h=783, cnt_v=514 equals {6'd31, 10'd639}. Count exactly 640x480 cycles with rgb_valid.
4. Drive pix_data=16'hFFFF constantly -> rgb=0 for all cnt_v<35 or >514, and for cnt_h<144 or >783. Count of rgb==FFFF per frame = 307200.
5. Assert sys_rst_n low at cnt_h=400, cnt_v=200 (asynchronously, mid-cycle) -> outputs reach reset values before the next edge. After release, the first frame_start-to-frame_start interval is 420000 clocks.
6. Check counter wrap: cnt_h=799, cnt_v=524 -> next clock both are 0 and frame_start=1; cnt_v never reaches 525.
